// File: rtl/mac_pkg.sv
// mac_pkg: widths, driver FSM states and the operand-pair type shared by the MAC stream driver.
package mac_pkg;
    localparam int WIDTH_IN  = 8;
    localparam int WIDTH_OUT = 16;
    typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, DONE} drv_state_t;
    typedef struct packed {
        logic signed [WIDTH_IN-1:0] a;
        logic signed [WIDTH_IN-1:0] b;
    } pair_t;
endpackage

// File: rtl/mac_pair_mem.sv
// mac_pair_mem: operand-pair register file with one write port and a combinational read port.
module mac_pair_mem
    import mac_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [2*WIDTH_IN-1:0] wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [2*WIDTH_IN-1:0] rdata_o
);
    pair_t mem_q [DEPTH];
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/mac_stream_driver.sv
// mac_stream_driver: clears a MAC and streams host-loaded operand pairs into it, then
// captures the final result and sticky overflow and reports done or a drain timeout.
module mac_stream_driver
    import mac_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int TIMEOUT = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 wr_en_i,
    input  logic [ADDR_W-1:0]    wr_addr_i,
    input  logic [WIDTH_IN-1:0]  wr_a_i,
    input  logic [WIDTH_IN-1:0]  wr_b_i,
    input  logic [ADDR_W:0]      len_i,
    input  logic                 start_i,
    input  logic                 bubble_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [WIDTH_OUT-1:0] result_o,
    output logic                 result_ovf_o,
    output logic                 mac_reset_o,
    output logic [WIDTH_IN-1:0]  mac_a_o,
    output logic [WIDTH_IN-1:0]  mac_b_o,
    output logic                 mac_valid_in_o,
    input  logic [WIDTH_OUT-1:0] mac_f_i,
    input  logic                 mac_valid_out_i,
    input  logic                 mac_overflow_i
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [TW-1:0] TMO_L = TW'(TIMEOUT);
    drv_state_t state_q, state_d;
    logic [ADDR_W:0] len_q, len_d, issue_q, issue_d, resp_q, resp_d, len_eff;
    logic [TW-1:0] tmo_q, tmo_d;
    logic issue, capture, timeout, accept;
    logic busy_q, done_q, error_q, ovf_q, mac_reset_q, mac_valid_q;
    logic [WIDTH_OUT-1:0] result_q;
    logic [WIDTH_IN-1:0] mac_a_q, mac_b_q;
    pair_t rd_pair;

    mac_pair_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_en_i && state_q == IDLE),
        .waddr_i (wr_addr_i),
        .wdata_i ({wr_a_i, wr_b_i}),
        .raddr_i (issue_q[ADDR_W-1:0]),
        .rdata_o (rd_pair)
    );

    // CLEAR already launches the first beat so it lands two cycles after the start edge
    always_comb begin
        len_eff = len_i > DEPTH_L ? DEPTH_L : len_i;
        accept  = state_q == IDLE && start_i;
        issue   = state_q == CLEAR || (state_q == ISSUE && issue_q != len_q && !bubble_i);
        capture = mac_valid_out_i && (state_q == ISSUE || state_q == DRAIN || state_q == DONE);
        tmo_d   = (state_q != DRAIN || mac_valid_out_i) ? '0 : tmo_q + 1'b1;
        issue_d = accept ? '0 : issue_q + {{ADDR_W{1'b0}}, issue};
        resp_d  = accept ? '0 : resp_q + {{ADDR_W{1'b0}}, capture};
        timeout = state_q == DRAIN && resp_d != len_q && tmo_d == TMO_L;
        len_d   = accept ? len_eff : len_q;
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = !start_i ? IDLE : (len_eff == '0 ? DONE : CLEAR);
            CLEAR:   state_d = ISSUE;
            ISSUE:   state_d = issue_q == len_q ? DRAIN : ISSUE;
            DRAIN:   state_d = (resp_d == len_q || timeout) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            len_q       <= '0;
            issue_q     <= '0;
            resp_q      <= '0;
            tmo_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            mac_reset_q <= 1'b1;
            mac_valid_q <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issue_q     <= issue_d;
            resp_q      <= resp_d;
            tmo_q       <= tmo_d;
            busy_q      <= state_d != IDLE;
            done_q      <= state_d == DONE;
            error_q     <= timeout;
            mac_reset_q <= state_d == CLEAR;
            mac_valid_q <= issue;
            if (issue) begin
                mac_a_q <= rd_pair.a;
                mac_b_q <= rd_pair.b;
            end
            if (accept) begin
                result_q <= '0;
                ovf_q    <= 1'b0;
            end else if (capture) begin
                result_q <= mac_f_i;
                ovf_q    <= ovf_q | mac_overflow_i;
            end
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign result_o       = result_q;
    assign result_ovf_o   = ovf_q;
    assign mac_reset_o    = mac_reset_q;
    assign mac_a_o        = mac_a_q;
    assign mac_b_o        = mac_b_q;
    assign mac_valid_in_o = mac_valid_q;
endmodule
